// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with active-low registered outputs.
// The displayed value is latched once per frame so a digit sweep never mixes two values.
module seg7_scan_mux #(
    parameter int unsigned N_DIGITS      = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  SCAN_CLK,
    input  logic                  ENABLE,
    input  logic [4*N_DIGITS-1:0] VALUE,
    input  logic [N_DIGITS-1:0]   DP,
    output logic [N_DIGITS-1:0]   AN,
    output logic [6:0]            SEG,
    output logic                  DP_OUT,
    output logic                  FRAME_START
);

    localparam int unsigned      IDX_W    = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic                  scan_d;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;

    logic                  advance_c;
    logic                  wrap_c;
    logic [IDX_W-1:0]      idx_next_c;
    logic                  upper_zero_c;
    logic [N_DIGITS-1:0]   blank_c;
    logic [3:0]            nibble_c;
    logic                  dp_sel_c;
    logic                  blank_sel_c;
    logic [N_DIGITS-1:0]   an_c;
    logic [6:0]            seg_c;

    // One advance per SCAN_CLK rising edge, regardless of its high time.
    assign advance_c = SCAN_CLK & ~scan_d;
    assign wrap_c    = advance_c & (idx == LAST_IDX);

    always_comb begin
        idx_next_c = idx;
        if (advance_c) begin
            idx_next_c = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Scan position, frame shadow registers and frame strobe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_d       <= 1'b0;
            idx          <= LAST_IDX;
            shadow_value <= '0;
            shadow_dp    <= '0;
            FRAME_START  <= 1'b0;
        end else begin
            scan_d      <= SCAN_CLK;
            idx         <= idx_next_c;
            FRAME_START <= wrap_c;
            if (wrap_c) begin
                shadow_value <= VALUE;
                shadow_dp    <= DP;
            end
        end
    end

    // Digit i>0 is blank when it and every more significant nibble are zero and its DP is off.
    always_comb begin
        upper_zero_c = 1'b1;
        blank_c      = '0;
        for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
            upper_zero_c = upper_zero_c & (shadow_value[4*i +: 4] == 4'h0);
            blank_c[i]   = BLANK_LEADING & upper_zero_c & ~shadow_dp[i];
        end
    end

    always_comb begin
        nibble_c    = 4'h0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        an_c        = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble_c    = shadow_value[4*i +: 4];
                dp_sel_c    = shadow_dp[i];
                blank_sel_c = blank_c[i];
                an_c[i]     = 1'b0;
            end
        end
    end

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    always_comb begin
        seg_c = SEG_OFF;
        case (nibble_c)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
            default: seg_c = SEG_OFF;
        endcase
    end

    // Output register; disabled or blanked digits show the dark pattern.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AN     <= '1;
            SEG    <= SEG_OFF;
            DP_OUT <= 1'b1;
        end else if (ENABLE && !blank_sel_c) begin
            AN     <= an_c;
            SEG    <= seg_c;
            DP_OUT <= ~dp_sel_c;
        end else begin
            AN     <= '1;
            SEG    <= SEG_OFF;
            DP_OUT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (4 digits, leading-zero blanking on):
// vector table, directed corner sequences, then random stimulus against a reference model.
module tb_seg7_scan_mux;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SCAN_CLK = 1'b0;
    logic        ENABLE = 1'b1;
    logic [15:0] VALUE = 16'h0;
    logic [3:0]  DP = 4'h0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP_OUT;
    logic        FRAME_START;

    int total = 0;
    int bad = 0;
    int fs_cnt;

    seg7_scan_mux #(.N_DIGITS(4), .BLANK_LEADING(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SCAN_CLK(SCAN_CLK), .ENABLE(ENABLE),
        .VALUE(VALUE), .DP(DP), .AN(AN), .SEG(SEG), .DP_OUT(DP_OUT),
        .FRAME_START(FRAME_START)
    );

    always #5 CLK = ~CLK;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // What the display should show for a digit position of a latched frame: {AN, SEG, DP_OUT}.
    function automatic logic [11:0] show(input logic [1:0] pos, input logic [15:0] v,
                                         input logic [3:0] d, input logic en);
        logic [3:0]  shamt;
        logic [15:0] upper;
        logic [3:0]  nib;
        shamt = {pos, 2'b00};
        upper = v >> shamt;
        nib   = upper[3:0];
        if (en && !(pos != 2'd0 && upper == 16'h0 && !d[pos]))
            return {~(4'b0001 << pos), seg_tab[nib], ~d[pos]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    // Reference model: digit position advances on each SCAN_CLK rise, frame latched on wrap.
    logic [1:0]  m_pos;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_prev;
    logic [12:0] m_exp;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_pos  <= 2'd3;
            m_val  <= 16'h0;
            m_dp   <= 4'h0;
            m_prev <= 1'b0;
            m_exp  <= {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            m_exp  <= {show(m_pos, m_val, m_dp, ENABLE), SCAN_CLK && !m_prev && m_pos == 2'd3};
            if (SCAN_CLK && !m_prev) begin
                m_pos <= m_pos + 2'd1;
                if (m_pos == 2'd3) begin
                    m_val <= VALUE;
                    m_dp  <= DP;
                end
            end
            m_prev <= SCAN_CLK;
        end
    end

    always @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) fs_cnt <= 0;
        else if (FRAME_START) fs_cnt <= fs_cnt + 1;
    end

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        en;
        logic [1:0]  digit;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_disp(input string name, input logic [3:0] an, input logic [6:0] seg,
                            input logic dpo);
        chk(name, 32'({AN, SEG, DP_OUT}), 32'({an, seg, dpo}));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input int hi, input int lo);
        SCAN_CLK = 1'b1;
        cyc(hi);
        SCAN_CLK = 1'b0;
        cyc(lo);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N  = 1'b0;
        SCAN_CLK = 1'b0;
        cyc(2);
        RESET_N = 1'b1;
        cyc(1);
    endtask

    initial begin
        vec_t v;
        logic [15:0] rv;

        vecs[0]  = '{16'h1234, 4'b0000, 1'b1, 2'd0, 4'b1110, 7'b0011001, 1'b1};
        vecs[1]  = '{16'h1234, 4'b0000, 1'b1, 2'd1, 4'b1101, 7'b0110000, 1'b1};
        vecs[2]  = '{16'h1234, 4'b0000, 1'b1, 2'd2, 4'b1011, 7'b0100100, 1'b1};
        vecs[3]  = '{16'h1234, 4'b0000, 1'b1, 2'd3, 4'b0111, 7'b1111001, 1'b1};
        vecs[4]  = '{16'h0007, 4'b0000, 1'b1, 2'd0, 4'b1110, 7'b1111000, 1'b1};
        vecs[5]  = '{16'h0007, 4'b0000, 1'b1, 2'd1, 4'b1111, 7'b1111111, 1'b1};
        vecs[6]  = '{16'h0007, 4'b0100, 1'b1, 2'd2, 4'b1011, 7'b1000000, 1'b0};
        vecs[7]  = '{16'h0007, 4'b0100, 1'b1, 2'd3, 4'b1111, 7'b1111111, 1'b1};
        vecs[8]  = '{16'h0007, 4'b0100, 1'b1, 2'd1, 4'b1111, 7'b1111111, 1'b1};
        vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 2'd0, 4'b1110, 7'b1000000, 1'b1};
        vecs[10] = '{16'hABCD, 4'b0001, 1'b1, 2'd0, 4'b1110, 7'b0100001, 1'b0};
        vecs[11] = '{16'h1234, 4'b0000, 1'b0, 2'd1, 4'b1111, 7'b1111111, 1'b1};
        vecs[12] = '{16'h0F00, 4'b0000, 1'b1, 2'd3, 4'b1111, 7'b1111111, 1'b1};
        vecs[13] = '{16'h0F00, 4'b0000, 1'b1, 2'd2, 4'b1011, 7'b0001110, 1'b1};
        vecs[14] = '{16'h0F00, 4'b0000, 1'b1, 2'd1, 4'b1101, 7'b1000000, 1'b1};
        vecs[15] = '{16'h89E6, 4'b1000, 1'b1, 2'd3, 4'b0111, 7'b0000000, 1'b0};
        vecs[16] = '{16'h89E6, 4'b0000, 1'b1, 2'd1, 4'b1101, 7'b0000110, 1'b1};
        vecs[17] = '{16'h0050, 4'b0000, 1'b1, 2'd0, 4'b1110, 7'b1000000, 1'b1};
        vecs[18] = '{16'h0050, 4'b0000, 1'b1, 2'd1, 4'b1101, 7'b0010010, 1'b1};

        // Reset state.
        do_reset();
        chk_disp("reset_disp", 4'hF, 7'h7F, 1'b1);
        chk("reset_fs", 32'(FRAME_START), 32'd0);

        // Vector table: fresh reset, load frame, advance to the requested digit.
        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            VALUE  = v.value;
            DP     = v.dp;
            ENABLE = v.en;
            do_reset();
            repeat (int'(v.digit) + 1) pulse(2, 2);
            chk_disp($sformatf("vec%0d", i), v.an, v.seg, v.dpo);
        end
        ENABLE = 1'b1;

        // Full scan: one frame strobe, on the first edge only.
        VALUE = 16'h1234;
        DP    = 4'h0;
        do_reset();
        pulse(2, 2);
        chk("scan_fs_first", 32'(fs_cnt), 32'd1);
        pulse(2, 2);
        pulse(2, 2);
        pulse(2, 2);
        chk_disp("scan_d3", 4'b0111, 7'b1111001, 1'b1);
        chk("scan_fs_once", 32'(fs_cnt), 32'd1);

        // Async reset mid-scan, right as the frame strobe is high.
        SCAN_CLK = 1'b1;
        @(posedge CLK);
        #2;
        chk("pre_reset_fs", 32'(FRAME_START), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk_disp("async_reset_disp", 4'hF, 7'h7F, 1'b1);
        chk("async_reset_fs", 32'(FRAME_START), 32'd0);
        SCAN_CLK = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc(1);
        pulse(2, 2);
        chk_disp("restart_d0", 4'b1110, 7'b0011001, 1'b1);

        // Edge detect: long high time and single-cycle pulse each advance once.
        do_reset();
        pulse(50, 2);
        chk_disp("long_high", 4'b1110, 7'b0011001, 1'b1);
        pulse(1, 2);
        chk_disp("short_pulse", 4'b1101, 7'b0110000, 1'b1);

        // Tear-free: VALUE change mid-frame shows up only on the next frame.
        do_reset();
        pulse(2, 2);
        pulse(2, 2);
        VALUE = 16'hABCD;
        pulse(2, 2);
        chk_disp("tear_d2", 4'b1011, 7'b0100100, 1'b1);
        pulse(2, 2);
        chk_disp("tear_d3", 4'b0111, 7'b1111001, 1'b1);
        pulse(2, 2);
        chk_disp("next_d0", 4'b1110, 7'b0100001, 1'b1);
        pulse(2, 2);
        chk_disp("next_d1", 4'b1101, 7'b1000110, 1'b1);
        pulse(2, 2);
        chk_disp("next_d2", 4'b1011, 7'b0000011, 1'b1);
        pulse(2, 2);
        chk_disp("next_d3", 4'b0111, 7'b0001000, 1'b1);

        // Disable for three advances; scanning and frame strobe keep running.
        VALUE = 16'h1234;
        do_reset();
        pulse(2, 2);
        ENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pulse(2, 2);
            chk_disp($sformatf("disabled%0d", k), 4'hF, 7'h7F, 1'b1);
        end
        ENABLE = 1'b1;
        cyc(1);
        chk_disp("reenable_d3", 4'b0111, 7'b1111001, 1'b1);
        pulse(2, 2);
        chk_disp("reenable_d0", 4'b1110, 7'b0011001, 1'b1);
        chk("enable_fs", 32'(fs_cnt), 32'd2);

        // Random stimulus against the reference model, compared every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            chk($sformatf("model_c%0d", c), 32'({AN, SEG, DP_OUT, FRAME_START}), 32'(m_exp));
            if ($urandom_range(0, 3) == 0) SCAN_CLK = ~SCAN_CLK;
            if ($urandom_range(0, 63) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 15) == 0) begin
                for (int k = 0; k < 4; k++)
                    rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                VALUE = rv;
                DP    = 4'($urandom) & 4'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
